// File: rtl/external_interrupt_gateway.sv
// External interrupt gateway: per-source IDLE/PENDING/INFLIGHT gateways, priority/enable/threshold
// arbitration, registered request/code outputs and a claim/complete handshake.
module external_interrupt_gateway #(
    parameter int unsigned NUM_SOURCES = 8,
    parameter int unsigned PRIO_WIDTH  = 3,
    parameter int unsigned ID_WIDTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] irqSrc,
    input  logic                   cfgWE,
    input  logic [1:0]             cfgSel,
    input  logic [ID_WIDTH-1:0]    cfgId,
    input  logic [PRIO_WIDTH-1:0]  cfgData,
    input  logic                   claimReq,
    input  logic                   completeReq,
    input  logic [ID_WIDTH-1:0]    completeId,
    output logic                   reqExternalInterrupt,
    output logic [ID_WIDTH-1:0]    externalInterruptCode,
    output logic                   claimValid,
    output logic [ID_WIDTH-1:0]    claimId
);

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_t;

    localparam logic [1:0] SEL_PRIO   = 2'd0;
    localparam logic [1:0] SEL_ENABLE = 2'd1;
    localparam logic [1:0] SEL_THRESH = 2'd2;

    gw_state_t              state_q [NUM_SOURCES];
    gw_state_t              state_d [NUM_SOURCES];
    logic [PRIO_WIDTH-1:0]  prio_q  [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] enable_q;
    logic [PRIO_WIDTH-1:0]  threshold_q;

    logic                   winner_valid_c;
    logic [ID_WIDTH-1:0]    winner_id_c;
    logic [PRIO_WIDTH-1:0]  winner_prio_c;

    // Arbitration: strict '>' scanning upward keeps the lowest ID on a priority tie.
    always_comb begin
        winner_valid_c = 1'b0;
        winner_id_c    = '0;
        winner_prio_c  = '0;
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            if (state_q[i] == GW_PENDING && enable_q[i] && prio_q[i] > threshold_q &&
                (!winner_valid_c || prio_q[i] > winner_prio_c)) begin
                winner_valid_c = 1'b1;
                winner_id_c    = ID_WIDTH'(i + 1);
                winner_prio_c  = prio_q[i];
            end
        end
    end

    // Gateway next state; claim only moves PENDING and complete only moves INFLIGHT, so they never collide.
    always_comb begin
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                GW_IDLE: begin
                    if (irqSrc[i]) state_d[i] = GW_PENDING;
                end
                GW_PENDING: begin
                    if (claimReq && winner_id_c == ID_WIDTH'(i + 1)) state_d[i] = GW_INFLIGHT;
                end
                GW_INFLIGHT: begin
                    if (completeReq && completeId == ID_WIDTH'(i + 1)) state_d[i] = GW_IDLE;
                end
                default: state_d[i] = GW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            if (rst) state_q[i] <= GW_IDLE;
            else     state_q[i] <= state_d[i];
        end
    end

    // Configuration registers; IDs outside 1..NUM_SOURCES match no source and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_SOURCES); i++) prio_q[i] <= '0;
            enable_q    <= '0;
            threshold_q <= '0;
        end else if (cfgWE) begin
            for (int i = 0; i < int'(NUM_SOURCES); i++) begin
                if (cfgId == ID_WIDTH'(i + 1)) begin
                    if (cfgSel == SEL_PRIO)   prio_q[i]   <= cfgData;
                    if (cfgSel == SEL_ENABLE) enable_q[i] <= cfgData[0];
                end
            end
            if (cfgSel == SEL_THRESH) threshold_q <= cfgData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reqExternalInterrupt  <= 1'b0;
            externalInterruptCode <= '0;
            claimValid            <= 1'b0;
            claimId               <= '0;
        end else begin
            reqExternalInterrupt  <= winner_valid_c;
            externalInterruptCode <= winner_id_c;
            claimValid            <= claimReq;
            claimId               <= claimReq ? winner_id_c : '0;
        end
    end

endmodule

// File: tb/tb_external_interrupt_gateway.sv
// Bench for external_interrupt_gateway: directed scenarios plus randomized traffic
// checked against a pending/inflight set model.
module tb_external_interrupt_gateway;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_sel = '0;
    logic [3:0] cfg_id = '0;
    logic [2:0] cfg_data = '0;
    logic       claim = 1'b0;
    logic       comp = 1'b0;
    logic [3:0] comp_id = '0;
    logic       req;
    logic [3:0] code;
    logic       cv;
    logic [3:0] cid;

    int checks = 0;
    int errors = 0;

    // Model: sets of pending and in-flight IDs plus the configuration.
    bit m_pend [0:N];
    bit m_infl [0:N];
    int m_prio [0:N];
    bit m_en   [0:N];
    int m_thr;
    int exp_req, exp_code, exp_cv, exp_cid;

    always #5 clk = ~clk;

    external_interrupt_gateway dut (
        .clk(clk), .rst(rst), .irqSrc(irq),
        .cfgWE(cfg_we), .cfgSel(cfg_sel), .cfgId(cfg_id), .cfgData(cfg_data),
        .claimReq(claim), .completeReq(comp), .completeId(comp_id),
        .reqExternalInterrupt(req), .externalInterruptCode(code),
        .claimValid(cv), .claimId(cid)
    );

    function automatic int model_winner();
        int w = 0;
        int best = 0;
        for (int id = 1; id <= N; id++)
            if (m_pend[id] && m_en[id] && m_prio[id] > m_thr && m_prio[id] > best) begin
                w = id;
                best = m_prio[id];
            end
        return w;
    endfunction

    // Advance the model by one clock with the currently driven inputs, then let the DUT clock.
    task automatic tick();
        int w;
        w = model_winner();
        if (rst) begin
            for (int id = 0; id <= N; id++) begin
                m_pend[id] = 0; m_infl[id] = 0; m_prio[id] = 0; m_en[id] = 0;
            end
            m_thr = 0;
            exp_req = 0; exp_code = 0; exp_cv = 0; exp_cid = 0;
        end else begin
            exp_req  = (w != 0) ? 1 : 0;
            exp_code = w;
            exp_cv   = claim ? 1 : 0;
            exp_cid  = claim ? w : 0;
            for (int id = 1; id <= N; id++) begin
                if (m_infl[id]) begin
                    if (comp && int'(comp_id) == id) m_infl[id] = 0;
                end else if (m_pend[id]) begin
                    if (claim && w == id) begin m_pend[id] = 0; m_infl[id] = 1; end
                end else if (irq[id-1]) begin
                    m_pend[id] = 1;
                end
            end
            if (cfg_we && cfg_id >= 1 && int'(cfg_id) <= N) begin
                if (cfg_sel == 2'd0) m_prio[cfg_id] = int'(cfg_data);
                if (cfg_sel == 2'd1) m_en[cfg_id] = cfg_data[0];
            end
            if (cfg_we && cfg_sel == 2'd2) m_thr = int'(cfg_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [3:0] id, input logic [2:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_id = id; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_claim();
        claim = 1'b1; tick(); claim = 1'b0;
    endtask

    task automatic do_complete(input logic [3:0] id);
        comp = 1'b1; comp_id = id; tick(); comp = 1'b0; comp_id = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks += 4;
        if (req !== 1'b0)  begin errors++; $display("FAIL reset_req got %0b want 0", req); end
        if (code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d want 0", code); end
        if (cv !== 1'b0)   begin errors++; $display("FAIL reset_cv got %0b want 0", cv); end
        if (cid !== 4'd0)  begin errors++; $display("FAIL reset_cid got %0d want 0", cid); end
    endtask

    task automatic test_basic();
        cfg_write(2'd0, 4'd3, 3'd5);
        cfg_write(2'd1, 4'd3, 3'd1);
        irq = 8'h04; tick();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL basic_latency_req got %0b want 0", req); end
        tick();
        checks += 2;
        if (req !== 1'b1)  begin errors++; $display("FAIL basic_req got %0b want 1", req); end
        if (code !== 4'd3) begin errors++; $display("FAIL basic_code got %0d want 3", code); end
        do_claim();
        checks += 2;
        if (cv !== 1'b1)  begin errors++; $display("FAIL basic_cv got %0b want 1", cv); end
        if (cid !== 4'd3) begin errors++; $display("FAIL basic_cid got %0d want 3", cid); end
        irq = 8'h00;
        do_complete(4'd3);
        tick(); tick();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL basic_idle_req got %0b want 0", req); end
    endtask

    task automatic test_tie();
        cfg_write(2'd0, 4'd2, 3'd4); cfg_write(2'd1, 4'd2, 3'd1);
        cfg_write(2'd0, 4'd5, 3'd4); cfg_write(2'd1, 4'd5, 3'd1);
        irq = 8'h12; tick(); irq = 8'h00; tick();
        checks++;
        if (code !== 4'd2) begin errors++; $display("FAIL tie_code got %0d want 2", code); end
        do_claim();
        checks += 2;
        if (cv !== 1'b1)  begin errors++; $display("FAIL tie_cv got %0b want 1", cv); end
        if (cid !== 4'd2) begin errors++; $display("FAIL tie_cid got %0d want 2", cid); end
        tick();
        checks += 2;
        if (cv !== 1'b0)   begin errors++; $display("FAIL tie_cv_pulse got %0b want 0", cv); end
        if (code !== 4'd5) begin errors++; $display("FAIL tie_next_code got %0d want 5", code); end
        claim = 1'b1; comp = 1'b1; comp_id = 4'd2; tick();
        claim = 1'b0; comp = 1'b0; comp_id = '0;
        checks++;
        if (cid !== 4'd5) begin errors++; $display("FAIL tie_claim_complete_cid got %0d want 5", cid); end
        do_complete(4'd5);
        tick(); tick();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL tie_idle_req got %0b want 0", req); end
    endtask

    task automatic test_threshold();
        cfg_write(2'd0, 4'd1, 3'd4); cfg_write(2'd1, 4'd1, 3'd1);
        cfg_write(2'd2, 4'd0, 3'd4);
        irq = 8'h01; tick(); irq = 8'h00; tick(); tick();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL thresh_equal_req got %0b want 0", req); end
        cfg_write(2'd2, 4'd0, 3'd3);
        tick();
        checks += 2;
        if (req !== 1'b1)  begin errors++; $display("FAIL thresh_lower_req got %0b want 1", req); end
        if (code !== 4'd1) begin errors++; $display("FAIL thresh_lower_code got %0d want 1", code); end
        do_claim(); do_complete(4'd1);
        cfg_write(2'd2, 4'd0, 3'd0);
    endtask

    task automatic test_repend();
        cfg_write(2'd0, 4'd6, 3'd6); cfg_write(2'd1, 4'd6, 3'd1);
        irq = 8'h20; tick(); tick();
        do_claim();
        checks++;
        if (cid !== 4'd6) begin errors++; $display("FAIL repend_cid got %0d want 6", cid); end
        tick();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL repend_inflight_req got %0b want 0", req); end
        do_complete(4'd6);
        tick();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL repend_gap_req got %0b want 0", req); end
        tick();
        checks += 2;
        if (req !== 1'b1)  begin errors++; $display("FAIL repend_req got %0b want 1", req); end
        if (code !== 4'd6) begin errors++; $display("FAIL repend_code got %0d want 6", code); end
        irq = 8'h00;
        do_claim(); do_complete(4'd6);
    endtask

    task automatic test_ignored_complete();
        cfg_write(2'd0, 4'd4, 3'd3); cfg_write(2'd1, 4'd4, 3'd1);
        irq = 8'h08; tick(); tick();
        do_claim();
        do_complete(4'd0); do_complete(4'd9); do_complete(4'd7);
        tick(); tick();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL ignored_complete_req got %0b want 0", req); end
        do_claim();
        checks += 2;
        if (cv !== 1'b1)  begin errors++; $display("FAIL empty_claim_cv got %0b want 1", cv); end
        if (cid !== 4'd0) begin errors++; $display("FAIL empty_claim_cid got %0d want 0", cid); end
        do_complete(4'd4);
        tick(); tick();
        checks++;
        if (code !== 4'd4) begin errors++; $display("FAIL real_complete_code got %0d want 4", code); end
        irq = 8'h00;
        do_claim(); do_complete(4'd4);
    endtask

    task automatic test_reset_mid();
        irq = 8'h08; tick(); tick();
        do_claim();
        irq = 8'h01; tick(); irq = 8'h00; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks += 4;
        if (req !== 1'b0)  begin errors++; $display("FAIL midreset_req got %0b want 0", req); end
        if (code !== 4'd0) begin errors++; $display("FAIL midreset_code got %0d want 0", code); end
        if (cv !== 1'b0)   begin errors++; $display("FAIL midreset_cv got %0b want 0", cv); end
        if (cid !== 4'd0)  begin errors++; $display("FAIL midreset_cid got %0d want 0", cid); end
        irq = 8'h08; tick(); irq = 8'h00; tick(); tick();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL postreset_req got %0b want 0", req); end
        do_claim();
        checks++;
        if (cid !== 4'd0) begin errors++; $display("FAIL postreset_cid got %0d want 0", cid); end
        cfg_write(2'd0, 4'd4, 3'd5); cfg_write(2'd1, 4'd4, 3'd1);
        tick();
        checks++;
        if (code !== 4'd4) begin errors++; $display("FAIL reenabled_code got %0d want 4", code); end
        do_claim(); do_complete(4'd4);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            irq      = 8'($urandom) & 8'($urandom);
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_sel  = 2'($urandom);
            cfg_id   = 4'($urandom);
            cfg_data = 3'($urandom);
            claim    = ($urandom_range(0, 4) == 0);
            comp     = ($urandom_range(0, 3) == 0);
            comp_id  = 4'($urandom);
            if ($urandom_range(0, 1) == 0)
                for (int id = 1; id <= N; id++)
                    if (m_infl[id]) comp_id = 4'(id);
            rst      = ($urandom_range(0, 399) == 0);
            tick();
            checks += 4;
            if (req !== 1'(exp_req))   begin errors++; $display("FAIL rand_req cyc %0d got %0b want %0d", c, req, exp_req); end
            if (code !== 4'(exp_code)) begin errors++; $display("FAIL rand_code cyc %0d got %0d want %0d", c, code, exp_code); end
            if (cv !== 1'(exp_cv))     begin errors++; $display("FAIL rand_cv cyc %0d got %0b want %0d", c, cv, exp_cv); end
            if (cid !== 4'(exp_cid))   begin errors++; $display("FAIL rand_cid cyc %0d got %0d want %0d", c, cid, exp_cid); end
        end
        rst = 1'b0; cfg_we = 1'b0; claim = 1'b0; comp = 1'b0; irq = '0;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_tie();
        test_threshold();
        test_repend();
        test_ignored_complete();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
